// File: rtl/timer_pkg.sv
// ---------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the countdown-timer scheduler.
//   - FSM state encoding (IDLE / COUNT / DONE)
//   - default tick rate and request-time width
//   - cnt_width(): counter width able to hold the product time*FREQ
//     without truncation
// ---------------------------------------------------------------------------
package timer_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] COUNT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam int DEF_FREQ     = 5;
  localparam int DEF_MAX_TIME = 10;

  // (2^max_time - 1) * freq < 2^(max_time + clog2(freq+1)), so the full
  // product of a request time and the tick rate always fits.
  function automatic int cnt_width(input int max_time, input int freq);
    return max_time + $clog2(freq + 1);
  endfunction

endpackage

// File: rtl/timer_rr_arb.sv
// ---------------------------------------------------------------------------
// timer_rr_arb
// Combinational round-robin pick. The search starts at ptr+1 and wraps
// modulo NREQ, so the requester granted last has the lowest priority.
// Ports:
//   req   in   NREQ   request vector
//   ptr   in   IDX_W  index of the previous winner
//   gnt   out  NREQ   one-hot grant (all zero when nothing is requested)
//   idx   out  IDX_W  index of the winner
//   valid out  1      at least one request present
// The pointer register itself lives in the caller.
// ---------------------------------------------------------------------------
module timer_rr_arb #(
  parameter int NREQ = 4,
  localparam int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Walk the offsets from farthest to nearest so that the nearest set bit
  // after ptr is the last one written and therefore wins.
  always_comb begin
    cand  = '0;
    idx   = '0;
    valid = 1'b0;
    gnt   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      cand = IDX_W'((int'(ptr) + off) % NREQ);
      if (req[cand]) begin
        idx   = cand;
        valid = 1'b1;
      end
    end
    if (valid) begin
      gnt[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/timer_sched.sv
// ---------------------------------------------------------------------------
// timer_sched
// Shared countdown-timer scheduler. NREQ requesters ask for a delay in time
// units; a round-robin arbiter picks one while idle and loads a single
// down-counter with time*FREQ ticks. Completion is reported to the granted
// requester one cycle after the DONE state is entered.
// Ports:
//   tsched_clock    in   1              clock, rising edge
//   tsched_rst      in   1              asynchronous active-high reset
//   tsched_req      in   NREQ           level request per requester
//   tsched_time     in   NREQ*MAX_TIME  delays, requester i at [i*MAX_TIME +: MAX_TIME]
//   tsched_abort    in   1              cancel the running countdown
//   tsched_ack      out  NREQ           one-cycle one-hot grant pulse
//   tsched_done     out  NREQ           one-cycle one-hot expiry pulse
//   tsched_aborted  out  1              one-cycle pulse on cancellation
//   tsched_busy     out  1              high while the FSM is not IDLE
//   tsched_gnt_idx  out  IDX_W          current / last granted requester
//   tsched_remain   out  CNT_W          current counter value
// ---------------------------------------------------------------------------
module timer_sched
  import timer_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int FREQ     = DEF_FREQ,
  parameter int MAX_TIME = DEF_MAX_TIME,
  localparam int CNT_W   = cnt_width(MAX_TIME, FREQ),
  localparam int IDX_W   = $clog2(NREQ)
) (
  input  logic                     tsched_clock,
  input  logic                     tsched_rst,
  input  logic [NREQ-1:0]          tsched_req,
  input  logic [NREQ*MAX_TIME-1:0] tsched_time,
  input  logic                     tsched_abort,
  output logic [NREQ-1:0]          tsched_ack,
  output logic [NREQ-1:0]          tsched_done,
  output logic                     tsched_aborted,
  output logic                     tsched_busy,
  output logic [IDX_W-1:0]         tsched_gnt_idx,
  output logic [CNT_W-1:0]         tsched_remain
);

  logic [1:0]          state;
  logic [CNT_W-1:0]    count;
  logic [IDX_W-1:0]    ptr;
  logic [IDX_W-1:0]    gnt_idx;

  logic [MAX_TIME-1:0] req_time [NREQ];
  logic [NREQ-1:0]     done_vec;
  logic [NREQ-1:0]     arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;
  logic [CNT_W-1:0]    load_val;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign req_time[gi] = tsched_time[gi*MAX_TIME +: MAX_TIME];
      assign done_vec[gi] = (gnt_idx == IDX_W'(gi));
    end
  endgenerate

  timer_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (tsched_req),
    .ptr   (ptr),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // Both operands are widened first so the product keeps every bit.
  assign load_val = CNT_W'(req_time[arb_idx]) * CNT_W'(FREQ);

  always_ff @(posedge tsched_clock or posedge tsched_rst) begin
    if (tsched_rst) begin
      state          <= IDLE;
      count          <= '0;
      ptr            <= IDX_W'(NREQ - 1);
      gnt_idx        <= '0;
      tsched_ack     <= '0;
      tsched_done    <= '0;
      tsched_aborted <= 1'b0;
      tsched_busy    <= 1'b0;
    end else begin
      tsched_ack     <= '0;
      tsched_done    <= '0;
      tsched_aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            state       <= COUNT;
            count       <= load_val;
            gnt_idx     <= arb_idx;
            ptr         <= arb_idx;
            tsched_ack  <= arb_gnt;
            tsched_busy <= 1'b1;
          end
        end
        COUNT: begin
          // Abort wins over both the decrement and the expiry transition.
          if (tsched_abort) begin
            state          <= IDLE;
            count          <= '0;
            tsched_aborted <= 1'b1;
            tsched_busy    <= 1'b0;
          end else if (count != '0) begin
            count <= count - CNT_W'(1);
          end else begin
            state <= DONE;
          end
        end
        DONE: begin
          // The expiry pulse appears as DONE is left, so it lands in the
          // first IDLE cycle; the next grant happens one edge later.
          tsched_done <= done_vec;
          state       <= IDLE;
          tsched_busy <= 1'b0;
        end
        default: begin
          state       <= IDLE;
          tsched_busy <= 1'b0;
        end
      endcase
    end
  end

  assign tsched_gnt_idx = gnt_idx;
  assign tsched_remain  = count;

endmodule

// File: tb/tb_timer_sched.sv
// ---------------------------------------------------------------------------
// tb_timer_sched
// Self-checking bench for timer_sched. A job-level reference model tracks
// the grant edge and tick count of the running job and derives every
// expected output from edge arithmetic; directed scenarios are followed by
// a randomized run.
// ---------------------------------------------------------------------------
module tb_timer_sched;

  localparam int NREQ     = 4;
  localparam int FREQ     = 5;
  localparam int MAX_TIME = 10;
  localparam int CNT_W    = 13;
  localparam int IDX_W    = 2;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NREQ-1:0]          req = '0;
  logic [NREQ*MAX_TIME-1:0] tvec = '0;
  logic                     abort = 1'b0;
  logic [NREQ-1:0]          ack;
  logic [NREQ-1:0]          done;
  logic                     aborted;
  logic                     busy;
  logic [IDX_W-1:0]         gnt_idx;
  logic [CNT_W-1:0]         remain;

  always #5 clk = ~clk;

  timer_sched #(
    .NREQ     (NREQ),
    .FREQ     (FREQ),
    .MAX_TIME (MAX_TIME)
  ) dut (
    .tsched_clock   (clk),
    .tsched_rst     (rst),
    .tsched_req     (req),
    .tsched_time    (tvec),
    .tsched_abort   (abort),
    .tsched_ack     (ack),
    .tsched_done    (done),
    .tsched_aborted (aborted),
    .tsched_busy    (busy),
    .tsched_gnt_idx (gnt_idx),
    .tsched_remain  (remain)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: job timeline in edge numbers.
  int              k         = 0;       // rising edges seen
  bit              active    = 1'b0;    // a job is granted and not yet ended
  int              g         = 0;       // edge of the current/last grant
  int              n_job     = 0;       // ticks loaded for that job
  int              ptr_m     = NREQ - 1;
  int              last_idx  = 0;
  int              free_edge = 0;       // first edge at which a grant may occur
  int              done_edge = 0;
  int              win       = 0;
  logic [NREQ-1:0] e_ack;
  logic [NREQ-1:0] e_done;
  bit              e_ab;
  int              e_remain  = 0;
  bit              auto_drop = 1'b1;
  int              grant_q[$];
  int              grant_edge_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  task automatic set_time(input int i, input int v);
    tvec[i*MAX_TIME +: MAX_TIME] = MAX_TIME'(v);
  endtask

  // One clock edge: advance the model with the inputs present at the edge,
  // then compare all outputs 1 time unit later.
  task automatic step();
    @(posedge clk);
    k++;
    e_ack  = '0;
    e_done = '0;
    e_ab   = 1'b0;
    if (active && abort && k <= g + n_job + 1) begin
      // Counting occupies edges g+1 .. g+n_job+1; an abort there cancels.
      e_ab      = 1'b1;
      active    = 1'b0;
      free_edge = k + 1;
      $display("edge %0d: requester %0d job aborted", k, last_idx);
    end else if (active && k == g + n_job + 2) begin
      e_done[last_idx] = 1'b1;
      active           = 1'b0;
      free_edge        = k + 1;
      done_edge        = k;
      $display("edge %0d: requester %0d done after %0d ticks", k, last_idx, n_job);
    end else if (!active && k >= free_edge && req != '0) begin
      win = -1;
      for (int off = 1; off <= NREQ; off++) begin
        if (win < 0 && req[(ptr_m + off) % NREQ]) win = (ptr_m + off) % NREQ;
      end
      ptr_m       = win;
      last_idx    = win;
      g           = k;
      n_job       = int'(tvec[win*MAX_TIME +: MAX_TIME]) * FREQ;
      active      = 1'b1;
      e_ack[win]  = 1'b1;
      grant_q.push_back(win);
      grant_edge_q.push_back(k);
      $display("edge %0d: grant requester %0d, %0d ticks", k, win, n_job);
    end
    e_remain = (active && (k - g) < n_job) ? n_job - (k - g) : 0;
    #1;
    chk("ack", 32'(ack), 32'(e_ack));
    chk("done", 32'(done), 32'(e_done));
    chk("aborted", 32'(aborted), 32'(e_ab));
    chk("gnt_idx", 32'(gnt_idx), 32'(last_idx));
    chk("remain", 32'(remain), 32'(e_remain));
    chk("busy", 32'(busy), 32'(active));
    if (auto_drop && e_ack != '0) req[win] = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant(input string tag);
    int budget;
    budget = 40;
    step();
    while (e_ack == '0 && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, 32'(e_ack != '0), 32'd1);
  endtask

  task automatic wait_remain(input string tag, input int target);
    int budget;
    budget = 200;
    while (e_remain != target && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, 32'(e_remain), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_aborted", 32'(aborted), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_gnt_idx", 32'(gnt_idx), 32'd0);
    chk("rst_remain", 32'(remain), 32'd0);
    active   = 1'b0;
    ptr_m    = NREQ - 1;
    last_idx = 0;
    abort    = 1'b0;
    repeat (2) begin
      @(posedge clk);
      k++;
    end
    #2 rst = 1'b0;
    free_edge = k + 1;
  endtask

  initial begin
    #2;
    do_reset();

    // Single request: time 3 -> 15 ticks, done 17 edges after the grant.
    set_time(0, 3);
    req = 4'b0001;
    step();
    chk("single_ack", 32'(ack), 32'h1);
    chk("single_load", 32'(remain), 32'd15);
    run(20);
    chk("single_latency", 32'(done_edge - g), 32'd17);

    // Zero delay: done two edges after the grant.
    set_time(2, 0);
    req = 4'b0100;
    wait_grant("zero_grant");
    run(4);
    chk("zero_latency", 32'(done_edge - g), 32'd2);

    // Round robin with all requests held, fresh pointer.
    do_reset();
    auto_drop = 1'b0;
    grant_q.delete();
    grant_edge_q.delete();
    for (int i = 0; i < NREQ; i++) set_time(i, 1);
    req = '1;
    run(40);
    req = '0;
    auto_drop = 1'b1;
    chk("rr_count", 32'(grant_q.size() >= 5), 32'd1);
    if (grant_q.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("rr_order", 32'(grant_q[i]), 32'(i % NREQ));
      for (int i = 1; i < 5; i++) chk("rr_spacing", 32'(grant_edge_q[i] - grant_edge_q[i-1]), 32'd8);
    end
    run(10);

    // Largest delay: full 13-bit product.
    set_time(0, 1023);
    req = 4'b0001;
    wait_grant("max_grant");
    chk("max_load", 32'(remain), 32'h13FB);
    run(5120);
    chk("max_latency", 32'(done_edge - g), 32'd5117);

    // Abort at remain 20 with requester 3 pending.
    set_time(1, 10);
    req = 4'b0010;
    wait_grant("abort_grant");
    set_time(3, 2);
    req[3] = 1'b1;
    wait_remain("abort_at20", 20);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_pulse", 32'(aborted), 32'd1);
    step();
    chk("abort_regrant", 32'(ack), 32'h8);
    run(20);

    // Reset in the middle of a job, then pointer restarts at requester 0.
    set_time(0, 10);
    req = 4'b0001;
    wait_grant("rstjob_grant");
    wait_remain("rstjob_at30", 30);
    do_reset();
    req = 4'b0011;
    step();
    chk("post_rst_first", 32'(ack), 32'h1);
    run(120);

    // Randomized traffic with occasional aborts.
    for (int c = 0; c < 3000; c++) begin
      step();
      abort = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < NREQ; i++) begin
        set_time(i, $urandom_range(0, 6));
        if (!req[i] && !e_ack[i] && $urandom_range(0, 11) == 0) req[i] = 1'b1;
      end
    end
    abort = 1'b0;
    req = '0;
    run(80);
    chk("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/timer_sched.md
Name: timer_sched

Overview:
Shared countdown-timer scheduler: up to NREQ requesters each ask for a delay in time units. A round-robin arbiter grants one requester at a time and loads a single shared down-counter with time*FREQ clock ticks. It signals per-requester completion. It sits between software/control FSMs needing delays and the one physical counter, replacing per-client timer instances.

Parameters:
NREQ, 4, number of requesters (2..8)
FREQ, 5, clock ticks per time unit (1..15)
MAX_TIME, 10, bit width of each requested time value
CNT_W (localparam), MAX_TIME + clog2(FREQ+1), counter width (13 at defaults)

Ports:
tsched_clock  input  1  system clock, rising edge
tsched_rst  input  1  reset; asynchronous, active-high
tsched_req  input  NREQ  level request per requester
tsched_time  input  NREQ*MAX_TIME  flattened delays; requester i at bits [i*MAX_TIME +: MAX_TIME]
tsched_abort  input  1  cancel the running countdown
tsched_ack  output  NREQ  one-cycle grant pulse, one-hot
tsched_done  output  NREQ  one-cycle expiry pulse, one-hot, to the granted requester
tsched_aborted  output  1  one-cycle pulse when a countdown is cancelled
tsched_busy  output  1  high when state != IDLE
tsched_gnt_idx  output  clog2(NREQ)  index of the current or last grant
tsched_remain  output  CNT_W  current counter value

Behaviour:
- Reset (async, tsched_rst=1): state=IDLE; count=0; ack, done, aborted, busy=0; gnt_idx=0; RR pointer=NREQ-1, so requester 0 wins first. Reset mid-countdown drops the job silently, with no done and no aborted.
- States: IDLE, COUNT, DONE.
- IDLE, with no req: hold. All pulse outputs are 0.
- IDLE, with any req bit set, at edge E0:
  - Winner = first set bit searching from ptr+1, wrapping modulo NREQ.
  - count <= time[winner]*FREQ, full CNT_W product, no truncation.
  - gnt_idx <= winner; ptr <= winner.
  - ack[winner]=1 for the following cycle only.
  - state <= COUNT.
- COUNT:
  - If count>0: decrement by 1 per edge.
  - If count==0: state <= DONE.
  - With N = time*FREQ, edges E1..EN decrement and edge E(N+1) enters DONE.
- DONE:
  - Lasts one cycle, with done[gnt_idx]=1.
  - Next edge goes to IDLE.
  - Arbitration resumes at the edge after that.
  - End to end: done is high during the cycle after edge E(N+2).
- Zero time: N=0, so COUNT lasts one cycle and done follows ack by exactly 2 cycles.
- Abort:
  - Acts only in COUNT.
  - Takes priority over decrement and over the count==0 transition.
  - aborted=1 for one cycle; state <= IDLE; count <= 0; no done.
  - Ignored in IDLE and DONE.
- Request protocol:
  - Requester must drop req in the cycle ack is seen.
  - A req still high after the job ends is a new request and is arbitrated normally.
  - req changes during COUNT or DONE do not affect the running job.
  - tsched_time is sampled only at the grant edge.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,2,...,NREQ-1,0. No requester waits more than NREQ-1 jobs.
- Outputs:
  - ack, done, aborted and busy are registered.
  - remain = count.
  - gnt_idx holds its value after a job finishes.

Decomposition:
- Shared package timer_pkg holds:
  - state encoding localparams (IDLE=2'd0, COUNT=2'd1, DONE=2'd2)
  - default FREQ and MAX_TIME
  - the CNT_W width function
- One sub-module, timer_rr_arb: combinational round-robin pick.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, index, any-valid.
  - Pointer update stays in timer_sched.

Test Plan:
- Single request: req=4'b0001, time0=3 after reset -> ack[0] at cycle 1, remain loads 15, done[0] exactly 17 cycles after ack, busy low the cycle after done.
- Zero delay: req[2], time2=0 -> ack[2] then done[2] 2 cycles later; remain stays 0.
- Round robin: all four req held with time=1 each -> ack order 0,1,2,3,0; each job spans ack-to-ack of 8 cycles (1+5+1+1).
- Max value: time=1023 -> remain loads 5115 (13'h13FB) with no truncation; done after 5117 cycles.
- Abort: time1=10, assert abort when remain=20 -> aborted pulse, no done[1], busy drops next cycle, pending req[3] granted on the following edge.
- Reset mid-job: time0=10, assert rst when remain=30 -> all outputs 0 immediately (asynchronous); after release, req[1] and req[0] together -> ack[0] first, since the pointer resets to NREQ-1.
